// File: rtl/ttt_move_ctrl.sv
// ttt_move_ctrl: debounced button front end that steers a wrapping 3x3 cursor and issues board commits
module ttt_move_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic [8:0] valid,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       reject,
  output logic       busy,
  output logic       fault
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COMMIT  = 3'd1;
  localparam logic [2:0] ACK     = 3'd2;
  localparam logic [2:0] REJECT  = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  logic [4:0] raw, s1, s2, stable, stable_d, press;
  logic [2:0] state, state_n;
  logic [1:0] row_n, col_n;
  logic       set_n, reject_n, fault_n;
  logic [3:0] idx;
  logic       blocked, up, down, left, right;
  assign raw = {btn_place, btn_right, btn_left, btn_down, btn_up};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1       <= '0;
      s2       <= '0;
      stable_d <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
    end
  // counter tracks consecutive samples that disagree with the accepted level
  genvar i;
  generate
    for (i = 0; i < 5; i++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            lvl;
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (s2[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= s2[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      assign stable[i] = lvl;
    end
  endgenerate
  assign press   = stable & ~stable_d;
  assign up      = press[0] & ~press[1];
  assign down    = press[1] & ~press[0];
  assign left    = press[2] & ~press[3];
  assign right   = press[3] & ~press[2];
  assign idx     = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  assign blocked = (|game_state) | valid[idx];
  assign busy    = state != IDLE;
  always_comb begin
    state_n  = state;
    row_n    = row;
    col_n    = col;
    set_n    = 1'b0;
    reject_n = 1'b0;
    fault_n  = fault;
    case (state)
      IDLE: begin
        if (press[4]) begin
          state_n  = blocked ? REJECT : COMMIT;
          set_n    = ~blocked;
          reject_n = blocked;
        end else begin
          row_n = up ? (row == 2'd0 ? 2'd2 : row - 2'd1) : down ? (row == 2'd2 ? 2'd0 : row + 2'd1) : row;
          col_n = left ? (col == 2'd0 ? 2'd2 : col - 2'd1) : right ? (col == 2'd2 ? 2'd0 : col + 2'd1) : col;
        end
      end
      COMMIT:  state_n = ACK;
      ACK: begin
        state_n = RELEASE;
        fault_n = fault | ~valid[idx];
      end
      REJECT:  state_n = RELEASE;
      RELEASE: state_n = stable[4] ? RELEASE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      row    <= 2'd0;
      col    <= 2'd0;
      set    <= 1'b0;
      reject <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_n;
      row    <= row_n;
      col    <= col_n;
      set    <= set_n;
      reject <= reject_n;
      fault  <= fault_n;
    end
endmodule

// File: tb/tb_ttt_move_ctrl.sv
// tb_ttt_move_ctrl: directed scenario tasks for the cursor/commit front end
module tb_ttt_move_ctrl;
  localparam int DB = 4;
  logic       clk = 0;
  logic       reset = 0;
  logic [4:0] btn = '0;
  logic [8:0] valid = '0;
  logic [1:0] game_state = '0;
  logic [1:0] row, col;
  logic       set, reject, busy, fault;
  int errors = 0, checks = 0;
  int set_cnt = 0, rej_cnt = 0, dbl = 0;
  logic prev_set = 0, prev_rej = 0;
  logic [1:0] set_row = 0, set_col = 0;

  ttt_move_ctrl #(.DB_CYCLES(DB), .DB_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_place(btn[4]),
    .valid(valid), .game_state(game_state),
    .row(row), .col(col), .set(set), .reject(reject), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (set) begin
      set_cnt++;
      set_row = row;
      set_col = col;
    end
    if (reject) rej_cnt++;
    if ((set && reject) || (set && prev_set) || (reject && prev_rej)) dbl++;
    prev_set = set;
    prev_rej = reject;
  end

  task automatic press(input logic [4:0] mask);
    btn = btn | mask;
    repeat (DB + 8) @(negedge clk);
    btn = btn & ~mask;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clk);
    checks++; if (row !== 2'd0) begin errors++; $display("FAIL reset_row got %0d want 0", row); end
    checks++; if (col !== 2'd0) begin errors++; $display("FAIL reset_col got %0d want 0", col); end
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL reset_set got %b want 0", set); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", reject); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    reset = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap;
    press(5'b00001);
    checks++; if ({row, col} !== {2'd2, 2'd0}) begin errors++; $display("FAIL wrap_up got (%0d,%0d) want (2,0)", row, col); end
    press(5'b00100);
    checks++; if ({row, col} !== {2'd2, 2'd2}) begin errors++; $display("FAIL wrap_left got (%0d,%0d) want (2,2)", row, col); end
    press(5'b00010);
    checks++; if ({row, col} !== {2'd0, 2'd2}) begin errors++; $display("FAIL wrap_down got (%0d,%0d) want (0,2)", row, col); end
    press(5'b00011);
    checks++; if ({row, col} !== {2'd0, 2'd2}) begin errors++; $display("FAIL up_down_cancel got (%0d,%0d) want (0,2)", row, col); end
    press(5'b01010);
    checks++; if ({row, col} !== {2'd1, 2'd0}) begin errors++; $display("FAIL down_right got (%0d,%0d) want (1,0)", row, col); end
  endtask

  task automatic test_debounce;
    for (int k = 0; k < 20; k++) begin
      btn[3] = ~btn[3];
      repeat (2) @(negedge clk);
    end
    checks++; if (col !== 2'd0) begin errors++; $display("FAIL bounce_nomove got %0d want 0", col); end
    btn[3] = 1;
    repeat (10) @(negedge clk);
    btn[3] = 0;
    repeat (DB + 8) @(negedge clk);
    checks++; if ({row, col} !== {2'd1, 2'd1}) begin errors++; $display("FAIL bounce_one_step got (%0d,%0d) want (1,1)", row, col); end
  endtask

  task automatic test_place;
    int k;
    valid = '0;
    game_state = 2'b00;
    set_cnt = 0; rej_cnt = 0;
    btn[4] = 1;
    k = 0;
    while (!set && k < 30) begin @(negedge clk); k++; end
    checks++; if (set !== 1'b1) begin errors++; $display("FAIL place_set got %b want 1", set); end
    checks++; if ({row, col} !== {2'd1, 2'd1}) begin errors++; $display("FAIL place_coord got (%0d,%0d) want (1,1)", row, col); end
    @(posedge clk) #1 valid[4] = 1;
    @(negedge clk);
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL place_pulse_width got %b want 0", set); end
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL place_busy_held got %b want 1", busy); end
    btn[4] = 0;
    k = 0;
    while (busy && k < 30) begin @(negedge clk); k++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL place_busy_release got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL place_fault got %b want 0", fault); end
    checks++; if (set_cnt !== 1) begin errors++; $display("FAIL place_set_count got %0d want 1", set_cnt); end
    checks++; if (rej_cnt !== 0) begin errors++; $display("FAIL place_rej_count got %0d want 0", rej_cnt); end
  endtask

  task automatic test_reject;
    valid = 9'b000010000;
    set_cnt = 0; rej_cnt = 0;
    press(5'b10000);
    checks++; if (rej_cnt !== 1) begin errors++; $display("FAIL occupied_reject got %0d want 1", rej_cnt); end
    checks++; if (set_cnt !== 0) begin errors++; $display("FAIL occupied_set got %0d want 0", set_cnt); end
    valid = '0;
    game_state = 2'b01;
    set_cnt = 0; rej_cnt = 0;
    press(5'b10000);
    checks++; if (rej_cnt !== 1) begin errors++; $display("FAIL gameover_reject got %0d want 1", rej_cnt); end
    checks++; if (set_cnt !== 0) begin errors++; $display("FAIL gameover_set got %0d want 0", set_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gameover_busy got %b want 0", busy); end
    game_state = 2'b00;
  endtask

  task automatic test_fault;
    valid = '0;
    set_cnt = 0;
    press(5'b10000);
    checks++; if (set_cnt !== 1) begin errors++; $display("FAIL noack_set got %0d want 1", set_cnt); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL noack_fault got %b want 1", fault); end
    repeat (20) @(negedge clk);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", fault); end
    set_cnt = 0;
    press(5'b10000);
    checks++; if (set_cnt !== 1) begin errors++; $display("FAIL set_after_fault got %0d want 1", set_cnt); end
    checks++; if ({set_row, set_col} !== {2'd1, 2'd1}) begin errors++; $display("FAIL set_after_fault_coord got (%0d,%0d) want (1,1)", set_row, set_col); end
  endtask

  task automatic test_reset_mid;
    int k;
    btn[4] = 1;
    k = 0;
    while (!set && k < 30) begin @(negedge clk); k++; end
    checks++; if (set !== 1'b1) begin errors++; $display("FAIL mid_reach_commit got %b want 1", set); end
    reset = 0;
    #1;
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL mid_set got %b want 0", set); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL mid_reject got %b want 0", reject); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault got %b want 0", fault); end
    checks++; if ({row, col} !== 4'b0000) begin errors++; $display("FAIL mid_cursor got (%0d,%0d) want (0,0)", row, col); end
    btn[4] = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    set_cnt = 0;
    repeat (20) @(negedge clk);
    checks++; if (set_cnt !== 0) begin errors++; $display("FAIL mid_no_late_set got %0d want 0", set_cnt); end
  endtask

  task automatic test_back_to_back;
    checks++; if (dbl !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", dbl); end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_debounce;
    test_place;
    test_reject;
    test_fault;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ttt_move_ctrl.md
# ttt_move_ctrl

Player-input front end for the tic-tac-toe board. It conditions five raw push-buttons (up, down, left, right, place) and steers a wrapping 3x3 cursor. It converts a place press into a single-cycle `set` with stable `row`/`col` for the board register block directly downstream. It reads back the board's `valid` and `game_state` so that presses on occupied cells or after game end are rejected before they reach the board.

## Interface

Parameters:
- `DB_CYCLES`, default 16: consecutive stable samples needed to accept a button level change; legal range 2..65535.
- `DB_W`, default 16: debounce counter width; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset; all state clears immediately on assertion.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_place` input 1 each: raw asynchronous buttons, active-high.
- `valid` input 9: board occupancy; bit index = row*3 + col.
- `game_state` input 2: 00 = in play; any nonzero value = game over.
- `row` output 2: cursor row, 0..2; 3 is never driven.
- `col` output 2: cursor column, 0..2; 3 is never driven.
- `set` output 1: one-cycle commit pulse to the board.
- `reject` output 1: one-cycle pulse when a place press is refused.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `fault` output 1: sticky; set when a commit was not acknowledged by `valid`.

## Operation

- Each button passes through a 2-flop synchronizer and then a per-button debouncer.
- A debouncer's stable level updates only after DB_CYCLES consecutive identical synchronized samples. A differing sample restarts its counter at 0.
- A rising edge of a stable level produces a one-cycle internal press.
- Cursor moves apply only in IDLE:
  - up: row−1, wrapping 0→2.
  - down: row+1, wrapping 2→0.
  - left: col−1, wrapping 0→2.
  - right: col+1, wrapping 2→0.
- If up and down press in the same cycle, neither applies. The same rule holds for left and right. A row move and a column move in the same cycle both apply.
- Presses that arrive outside IDLE are dropped, not queued.
- idx = row*3 + col, computed combinationally from the cursor registers (0..8).
- FSM states:
  - IDLE: on a place press:
    - game_state≠00 or valid[idx]=1 → REJECT.
    - otherwise → COMMIT.
    - A move press in the same cycle as a place press is ignored; place wins and the cursor is unchanged.
  - COMMIT: `set`=1 for this single cycle → ACK.
  - ACK: sample valid[idx]. If 0, set `fault`. Go to RELEASE either way.
  - REJECT: `reject`=1 for this single cycle → RELEASE.
  - RELEASE: stay until the place stable level is 0 → IDLE.
- `row`/`col` are frozen from leaving IDLE until re-entering IDLE, so the board always sees stable coordinates around `set`.
- `fault` clears only on reset.

## Timing

- Reset values:
  - row=0, col=0, set=0, reject=0, busy=0, fault=0.
  - FSM=IDLE.
  - Synchronizers, stable levels and debounce counters all 0.
- Press latency: 2 synchronizer cycles + DB_CYCLES samples + 1 edge cycle. The internal press is seen DB_CYCLES+3 cycles after the raw rising edge (±1 for async sampling).
- Cursor move latency: outputs update on the clock edge that consumes the press, one cycle after the internal press.
- Place latency: `set` is high in the cycle after IDLE sees the press. `valid` is checked one cycle after `set`, because the board registers on the same edge that ends `set`.
- `set` and `reject` are registered outputs. They are never high together and never high for two consecutive cycles.
- Minimum spacing between two `set` pulses is 4 cycles (IDLE, COMMIT, ACK, RELEASE), plus the release debounce time.
- A `game_state` change while in COMMIT/ACK has no effect on that commit.
- Reset asserted mid-operation aborts immediately: any `set` in flight is dropped and the cursor returns to (0,0).

## Test plan

- Reset behaviour: assert reset low mid-COMMIT → set, reject, busy and fault are 0 at once; row=0, col=0; FSM in IDLE.
- Cursor wrap, DB_CYCLES=4: press up from (0,0) → (2,0). Press left → (2,2). Press down → (0,2). Simultaneous up+down → unchanged.
- Debounce: toggle btn_right every 2 cycles for 40 cycles, then hold high for 10 → exactly one column increment.
- Legal place: cursor (1,1), valid=0, game_state=00, press place → set=1 for one cycle with row=1, col=1; then a bench model drives valid[4]=1 → fault stays 0; busy drops after release.
- Occupied and game-over cases:
  - valid[4]=1, press place at (1,1) → reject pulse, no set.
  - game_state=01 at an empty cell → reject pulse, no set.
- Missing acknowledge: valid held at 0 after set → fault=1 and stays 1 until reset; a later legal press still produces set.
